// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared grant encoding and watchdog sizing for the two-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } grant_t;

  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - pending-strobe tracker that pulses timeout when the slave never acks
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic s_cyc,
  input  logic s_stb,
  input  logic s_stall,
  input  logic s_ack,
  output logic timeout
);

  logic             pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept  = s_cyc & s_stb & ~s_stall;
  assign timeout = pending_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Dropping cyc or timing out abandons the outstanding strobe; an ack may coincide with a new accept.
  always_ff @(posedge clk) begin
    if (reset || !s_cyc || timeout) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else if (s_ack) begin
      pending_q <= accept;
      cnt_q     <= '0;
    end else if (pending_q) begin
      cnt_q     <= cnt_q + 1'b1;
    end else if (accept) begin
      pending_q <= 1'b1;
      cnt_q     <= '0;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin two-master Wishbone arbiter with cyc-based locking
// Define WB_ARB_TIMEOUT_EN to add the missing-ack watchdog and err responses.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_m0_wb_cyc,
  input  logic          i_m0_wb_stb,
  input  logic          i_m0_wb_we,
  input  logic [AW-1:0] i_m0_wb_addr,
  input  logic [DW-1:0] i_m0_wb_data,
  output logic          o_m0_wb_ack,
  output logic          o_m0_wb_stall,
  output logic          o_m0_wb_err,
  output logic [DW-1:0] o_m0_wb_data,
  input  logic          i_m1_wb_cyc,
  input  logic          i_m1_wb_stb,
  input  logic          i_m1_wb_we,
  input  logic [AW-1:0] i_m1_wb_addr,
  input  logic [DW-1:0] i_m1_wb_data,
  output logic          o_m1_wb_ack,
  output logic          o_m1_wb_stall,
  output logic          o_m1_wb_err,
  output logic [DW-1:0] o_m1_wb_data,
  output logic          o_s_wb_cyc,
  output logic          o_s_wb_stb,
  output logic          o_s_wb_we,
  output logic [AW-1:0] o_s_wb_addr,
  output logic [DW-1:0] o_s_wb_data,
  input  logic          i_s_wb_ack,
  input  logic          i_s_wb_stall,
  input  logic [DW-1:0] i_s_wb_data
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES out of range 2..255");
  end

  grant_t grant_q, grant_d;
  logic   last_gnt_q, last_gnt_d;
  logic   timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      grant_q    <= grant_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    grant_d    = grant_q;
    last_gnt_d = last_gnt_q;
    case (grant_q)
      IDLE: begin
        if (i_m0_wb_cyc && i_m1_wb_cyc) grant_d = last_gnt_q ? GNT0 : GNT1;
        else if (i_m0_wb_cyc)           grant_d = GNT0;
        else if (i_m1_wb_cyc)           grant_d = GNT1;
      end
      GNT0: begin
        if (timeout) begin
          grant_d    = IDLE;
          last_gnt_d = 1'b0;
        end else if (!i_m0_wb_cyc) begin
          grant_d    = i_m1_wb_cyc ? GNT1 : IDLE;
          last_gnt_d = 1'b0;
        end
      end
      GNT1: begin
        if (timeout) begin
          grant_d    = IDLE;
          last_gnt_d = 1'b1;
        end else if (!i_m1_wb_cyc) begin
          grant_d    = i_m0_wb_cyc ? GNT0 : IDLE;
          last_gnt_d = 1'b1;
        end
      end
      default: grant_d = IDLE;
    endcase
  end

  always_comb begin
    o_s_wb_cyc  = 1'b0;
    o_s_wb_stb  = 1'b0;
    o_s_wb_we   = 1'b0;
    o_s_wb_addr = '0;
    o_s_wb_data = '0;
    if (grant_q == GNT0) begin
      o_s_wb_cyc  = i_m0_wb_cyc;
      o_s_wb_stb  = i_m0_wb_stb;
      o_s_wb_we   = i_m0_wb_we;
      o_s_wb_addr = i_m0_wb_addr;
      o_s_wb_data = i_m0_wb_data;
    end else if (grant_q == GNT1) begin
      o_s_wb_cyc  = i_m1_wb_cyc;
      o_s_wb_stb  = i_m1_wb_stb;
      o_s_wb_we   = i_m1_wb_we;
      o_s_wb_addr = i_m1_wb_addr;
      o_s_wb_data = i_m1_wb_data;
    end
  end

  // Gating with the owner's cyc drops acks that arrive after the owner abandoned its cycle.
  assign o_m0_wb_ack   = (grant_q == GNT0) & i_m0_wb_cyc & i_s_wb_ack;
  assign o_m1_wb_ack   = (grant_q == GNT1) & i_m1_wb_cyc & i_s_wb_ack;
  assign o_m0_wb_stall = (grant_q == GNT0) ? i_s_wb_stall : 1'b1;
  assign o_m1_wb_stall = (grant_q == GNT1) ? i_s_wb_stall : 1'b1;
  assign o_m0_wb_data  = i_s_wb_data;
  assign o_m1_wb_data  = i_s_wb_data;
  assign o_m0_wb_err   = timeout & (grant_q == GNT0);
  assign o_m1_wb_err   = timeout & (grant_q == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .s_cyc   (o_s_wb_cyc),
    .s_stb   (o_s_wb_stb),
    .s_stall (i_s_wb_stall),
    .s_ack   (i_s_wb_ack),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we;
  logic [31:0] i_m0_wb_addr, i_m0_wb_data;
  logic        o_m0_wb_ack, o_m0_wb_stall, o_m0_wb_err;
  logic [31:0] o_m0_wb_data;
  logic        i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we;
  logic [31:0] i_m1_wb_addr, i_m1_wb_data;
  logic        o_m1_wb_ack, o_m1_wb_stall, o_m1_wb_err;
  logic [31:0] o_m1_wb_data;
  logic        o_s_wb_cyc, o_s_wb_stb, o_s_wb_we;
  logic [31:0] o_s_wb_addr, o_s_wb_data;
  logic        i_s_wb_ack, i_s_wb_stall;
  logic [31:0] i_s_wb_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] leds;

  wb_arbiter_2m dut (
    .clk(clk), .reset(reset),
    .i_m0_wb_cyc(i_m0_wb_cyc), .i_m0_wb_stb(i_m0_wb_stb), .i_m0_wb_we(i_m0_wb_we),
    .i_m0_wb_addr(i_m0_wb_addr), .i_m0_wb_data(i_m0_wb_data),
    .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_stall(o_m0_wb_stall), .o_m0_wb_err(o_m0_wb_err),
    .o_m0_wb_data(o_m0_wb_data),
    .i_m1_wb_cyc(i_m1_wb_cyc), .i_m1_wb_stb(i_m1_wb_stb), .i_m1_wb_we(i_m1_wb_we),
    .i_m1_wb_addr(i_m1_wb_addr), .i_m1_wb_data(i_m1_wb_data),
    .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_stall(o_m1_wb_stall), .o_m1_wb_err(o_m1_wb_err),
    .o_m1_wb_data(o_m1_wb_data),
    .o_s_wb_cyc(o_s_wb_cyc), .o_s_wb_stb(o_s_wb_stb), .o_s_wb_we(o_s_wb_we),
    .o_s_wb_addr(o_s_wb_addr), .o_s_wb_data(o_s_wb_data),
    .i_s_wb_ack(i_s_wb_ack), .i_s_wb_stall(i_s_wb_stall), .i_s_wb_data(i_s_wb_data)
  );

  always #5 clk = ~clk;

  // LED register of the shared peripheral, written through the slave port.
  always @(posedge clk) begin
    if (reset) leds <= 8'h00;
    else if (o_s_wb_cyc && o_s_wb_stb && o_s_wb_we && i_s_wb_ack && o_s_wb_addr == 32'h3000_0000)
      leds <= o_s_wb_data[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_m0_wb_we = 0; i_m0_wb_addr = '0; i_m0_wb_data = '0;
    i_m1_wb_cyc = 0; i_m1_wb_stb = 0; i_m1_wb_we = 0; i_m1_wb_addr = '0; i_m1_wb_data = '0;
    i_s_wb_ack = 0; i_s_wb_stall = 0; i_s_wb_data = '0;
  endtask

  task automatic do_reset;
    reset = 1;
    tick;
    tick;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int   order[8];
  int   n, rem0, rem1;
  logic acked0, acked1, rel0, rel1;

  initial begin
    idle_all;
    do_reset;
    #1;
    check("rst_s_cyc", o_s_wb_cyc, 0);
    check("rst_m0_stall", o_m0_wb_stall, 1);
    check("rst_m1_stall", o_m1_wb_stall, 1);
    check("rst_acks", {o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_err, o_m1_wb_err}, 0);

    // Single write by m0
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_we = 1;
    i_m0_wb_addr = 32'h3000_0000; i_m0_wb_data = 32'h0000_00A5;
    #1;
    check("wr_latency_stall", o_m0_wb_stall, 1);
    check("wr_latency_cyc", o_s_wb_cyc, 0);
    tick;
    check("wr_m0_stall", o_m0_wb_stall, 0);
    check("wr_m1_stall", o_m1_wb_stall, 1);
    check("wr_s_ctrl", {o_s_wb_cyc, o_s_wb_stb, o_s_wb_we}, 3'b111);
    check("wr_s_addr", o_s_wb_addr, 32'h3000_0000);
    check("wr_s_data", o_s_wb_data, 32'h0000_00A5);
    i_s_wb_ack = 1;
    #1;
    check("wr_m0_ack", o_m0_wb_ack, 1);
    check("wr_m1_ack", o_m1_wb_ack, 0);
    tick;
    i_s_wb_ack = 0; i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_m0_wb_we = 0;
    #1;
    check("wr_leds", leds, 8'hA5);
    check("wr_m1_stall_end", o_m1_wb_stall, 1);
    tick;
    check("wr_back_idle", {o_m0_wb_stall, o_m1_wb_stall, o_s_wb_cyc}, 3'b110);

    // Simultaneous requests after reset: m0 first, then direct handover to m1
    do_reset;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_we = 1; i_m0_wb_addr = 32'h3000_0000;
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_we = 0; i_m1_wb_addr = 32'h3000_0004;
    tick;
    check("tie_m0_granted", o_m0_wb_stall, 0);
    check("tie_m1_waits", o_m1_wb_stall, 1);
    i_s_wb_ack = 1;
    tick;
    i_s_wb_ack = 0; i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
    #1;
    check("handover_pending", o_m1_wb_stall, 1);
    tick;
    check("handover_m1", o_m1_wb_stall, 0);
    check("handover_addr", o_s_wb_addr, 32'h3000_0004);
    check("handover_we", o_s_wb_we, 0);
    i_s_wb_data = 32'h0000_0005; i_s_wb_ack = 1;
    #1;
    check("rd_m1_ack", o_m1_wb_ack, 1);
    check("rd_m0_ack", o_m0_wb_ack, 0);
    check("rd_m1_data", o_m1_wb_data, 32'h0000_0005);
    check("rd_m0_data", o_m0_wb_data, 32'h0000_0005);
    tick;
    idle_all;
    tick;

    // Fairness: 4 single cycles per master, both contending
    do_reset;
    rem0 = 4; rem1 = 4; n = 0;
    acked0 = 0; acked1 = 0; rel0 = 0; rel1 = 0;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m1_wb_cyc = 1; i_m1_wb_stb = 1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick;
      i_s_wb_ack = 0;
      if (acked0) begin i_m0_wb_cyc = 0; i_m0_wb_stb = 0; acked0 = 0; rel0 = (rem0 > 0); end
      else if (rel0) begin i_m0_wb_cyc = 1; i_m0_wb_stb = 1; rel0 = 0; end
      if (acked1) begin i_m1_wb_cyc = 0; i_m1_wb_stb = 0; acked1 = 0; rel1 = (rem1 > 0); end
      else if (rel1) begin i_m1_wb_cyc = 1; i_m1_wb_stb = 1; rel1 = 0; end
      #1;
      if (!o_m0_wb_stall && i_m0_wb_cyc) begin
        order[n] = 0; n++; rem0--; i_s_wb_ack = 1; acked0 = 1;
      end else if (!o_m1_wb_stall && i_m1_wb_cyc) begin
        order[n] = 1; n++; rem1--; i_s_wb_ack = 1; acked1 = 1;
      end
    end
    check("fair_count", n, 8);
    for (int k = 0; k < 8; k++) check($sformatf("fair_order_%0d", k), order[k], k % 2);
    tick;
    idle_all;
    tick;
    tick;

    // Reset while m1 owns the bus with a strobe outstanding
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_addr = 32'h3000_0004;
    tick;
    check("mid_m1_granted", o_m1_wb_stall, 0);
    reset = 1;
    tick;
    i_s_wb_ack = 1;
    #1;
    check("mid_s_cyc", o_s_wb_cyc, 0);
    check("mid_acks", {o_m0_wb_ack, o_m1_wb_ack}, 2'b00);
    check("mid_stalls", {o_m0_wb_stall, o_m1_wb_stall}, 2'b11);
    i_s_wb_ack = 0;
    reset = 0;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1;
    tick;
    check("post_rst_tie_m0", o_m0_wb_stall, 0);
    check("post_rst_tie_m1", o_m1_wb_stall, 1);
    idle_all;
    tick;
    tick;

    // Stray ack in IDLE
    i_s_wb_ack = 1;
    #1;
    check("stray_acks", {o_m0_wb_ack, o_m1_wb_ack}, 2'b00);
    i_s_wb_ack = 0;
    tick;

    // m0 reads an unmapped address and the slave never acks; m1 waits behind it
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_we = 0; i_m0_wb_addr = 32'h3000_0010;
    tick;
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_addr = 32'h3000_0004;
    tick;
    i_m0_wb_stb = 0;
`ifdef WB_ARB_TIMEOUT_EN
    repeat (15) tick;
    check("to_err_early", o_m0_wb_err, 0);
    tick;
    check("to_err_pulse", o_m0_wb_err, 1);
    check("to_m1_err", o_m1_wb_err, 0);
    tick;
    check("to_err_single", o_m0_wb_err, 0);
    check("to_forced_idle", o_s_wb_cyc, 0);
    check("to_idle_stalls", {o_m0_wb_stall, o_m1_wb_stall}, 2'b11);
    i_s_wb_ack = 1;
    #1;
    check("to_late_ack", o_m0_wb_ack, 0);
    i_s_wb_ack = 0;
    tick;
    check("to_m1_next", o_m1_wb_stall, 0);
`else
    repeat (16) tick;
    check("hold_errs", {o_m0_wb_err, o_m1_wb_err}, 2'b00);
    check("hold_m0_owner", o_m0_wb_stall, 0);
    check("hold_s_cyc", o_s_wb_cyc, 1);
    i_s_wb_ack = 1;
    #1;
    check("hold_late_ack", o_m0_wb_ack, 1);
    tick;
    i_s_wb_ack = 0; i_m0_wb_cyc = 0;
    tick;
    check("hold_m1_next", o_m1_wb_stall, 0);
`endif
    idle_all;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
